// File: rtl/ps2_frame_receiver_pkg.sv
// Shared constants, FSM encoding and parity helper for the PS/2 frame receiver.
package ps2_frame_receiver_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } ps2_state_t;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// N-stage synchroniser for one asynchronous line with a falling-edge detector.
// Latency: STAGES cycles to the level output; fall is valid in the same cycle as the level.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign fall  = hist_q & ~level;

endmodule

// File: rtl/ps2_frame_receiver.sv
// Deserialises PS/2 frames in the clock50 domain, checks framing/parity and folds E0/F0 prefixes.
// Strobes scanValid or frameError one cycle after the stop-bit falling edge; there is no backpressure.
module ps2_frame_receiver
    import ps2_frame_receiver_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock50,
    input  logic       resetN,
    input  logic       keyboardClock,
    input  logic       keyboardData,
    output logic [7:0] scanCode,
    output logic       scanValid,
    output logic       isBreak,
    output logic       isExtended,
    output logic       frameError
);

    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic            ps2_clk_lvl_unused;
    logic            ps2_clk_fall;
    logic            ps2_dat;
    logic            data_fall_unused;
    ps2_state_t      state;
    logic [3:0]      bit_count;
    logic [9:0]      shift_reg;
    logic [TO_W-1:0] to_cnt;
    logic            ext_pend;
    logic            brk_pend;
    logic [9:0]      frame;

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (clock50),
        .rst_n (resetN),
        .din   (keyboardClock),
        .level (ps2_clk_lvl_unused),
        .fall  (ps2_clk_fall)
    );

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_dat_sync (
        .clk   (clock50),
        .rst_n (resetN),
        .din   (keyboardData),
        .level (ps2_dat),
        .fall  (data_fall_unused)
    );

    // Shift view including the bit being taken now; on the stop edge this is the whole frame
    // as {stop, parity, data[7:0]}.
    assign frame = {ps2_dat, shift_reg[9:1]};

    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            bit_count  <= '0;
            shift_reg  <= '0;
            to_cnt     <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            scanCode   <= '0;
            scanValid  <= 1'b0;
            isBreak    <= 1'b0;
            isExtended <= 1'b0;
            frameError <= 1'b0;
        end else begin
            scanValid  <= 1'b0;
            frameError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (ps2_clk_fall && !ps2_dat) begin
                        state     <= ST_RECV;
                        bit_count <= 4'd1;
                    end
                end
                ST_RECV: begin
                    // Timeout is checked first so a coincident edge is discarded.
                    if (to_cnt == TO_LAST) begin
                        frameError <= 1'b1;
                        ext_pend   <= 1'b0;
                        brk_pend   <= 1'b0;
                        state      <= ST_IDLE;
                        bit_count  <= '0;
                        to_cnt     <= '0;
                    end else if (ps2_clk_fall) begin
                        to_cnt    <= '0;
                        shift_reg <= frame;
                        bit_count <= bit_count + 4'd1;
                        if (bit_count == LAST_BIT) begin
                            state     <= ST_IDLE;
                            bit_count <= '0;
                            if (frame[9] && ps2_parity_ok(frame[8:0])) begin
                                if (frame[7:0] == PS2_PREFIX_EXT) begin
                                    ext_pend <= 1'b1;
                                end else if (frame[7:0] == PS2_PREFIX_BRK) begin
                                    brk_pend <= 1'b1;
                                end else begin
                                    scanCode   <= frame[7:0];
                                    isBreak    <= brk_pend;
                                    isExtended <= ext_pend;
                                    scanValid  <= 1'b1;
                                    ext_pend   <= 1'b0;
                                    brk_pend   <= 1'b0;
                                end
                            end else begin
                                frameError <= 1'b1;
                                ext_pend   <= 1'b0;
                                brk_pend   <= 1'b0;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver with a short timeout and a fast PS/2 bit rate.
module tb_ps2_frame_receiver;

    localparam int TIMEOUT = 200;

    logic       clock50 = 1'b0;
    logic       resetN = 1'b0;
    logic       keyboardClock = 1'b1;
    logic       keyboardData = 1'b1;
    logic [7:0] scanCode;
    logic       scanValid;
    logic       isBreak;
    logic       isExtended;
    logic       frameError;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0;
    int e0;
    logic [7:0] cap_code = 8'h00;
    logic       cap_brk = 1'b0;
    logic       cap_ext = 1'b0;

    ps2_frame_receiver #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock50       (clock50),
        .resetN        (resetN),
        .keyboardClock (keyboardClock),
        .keyboardData  (keyboardData),
        .scanCode      (scanCode),
        .scanValid     (scanValid),
        .isBreak       (isBreak),
        .isExtended    (isExtended),
        .frameError    (frameError)
    );

    always #10 clock50 = ~clock50;

    always @(negedge clock50) begin
        if (scanValid) begin
            valid_cnt = valid_cnt + 1;
            cap_code  = scanCode;
            cap_brk   = isBreak;
            cap_ext   = isExtended;
        end
        if (frameError) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Data changes mid-way through the high phase; a bit lasts 800 time units (40 clock50 cycles).
    task automatic send_bit(input logic b);
        #200 keyboardData = b;
        #200 keyboardClock = 1'b0;
        #400 keyboardClock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ flip_parity);
        send_bit(1'b1);
        #200 keyboardData = 1'b1;
        #1000;
    endtask

    task automatic mark();
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        #5;
        #100;
        check("rst_scancode", 32'(scanCode), 32'h00);
        check("rst_valid", 32'(scanValid), 32'h0);
        check("rst_break", 32'(isBreak), 32'h0);
        check("rst_ext", 32'(isExtended), 32'h0);
        check("rst_err", 32'(frameError), 32'h0);
        resetN = 1'b1;
        #200;

        // 1: plain make code
        mark();
        send_frame(8'h1C, 1'b0);
        check("t1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("t1_err_cnt", 32'(err_cnt - e0), 32'd0);
        check("t1_code", 32'(cap_code), 32'h1C);
        check("t1_break", 32'(cap_brk), 32'h0);
        check("t1_ext", 32'(cap_ext), 32'h0);
        check("t1_hold_code", 32'(scanCode), 32'h1C);

        // 2: break prefix, then a plain code clears the flag
        mark();
        send_frame(8'hF0, 1'b0);
        check("t2_f0_no_strobe", 32'(valid_cnt - v0), 32'd0);
        check("t2_f0_hold_code", 32'(scanCode), 32'h1C);
        send_frame(8'h1C, 1'b0);
        check("t2_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("t2_code", 32'(cap_code), 32'h1C);
        check("t2_break", 32'(cap_brk), 32'h1);
        check("t2_ext", 32'(cap_ext), 32'h0);
        send_frame(8'h32, 1'b0);
        check("t2_next_code", 32'(cap_code), 32'h32);
        check("t2_next_break", 32'(cap_brk), 32'h0);

        // 3: E0 F0 75, then repeated F0
        mark();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("t3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("t3_code", 32'(cap_code), 32'h75);
        check("t3_ext", 32'(cap_ext), 32'h1);
        check("t3_break", 32'(cap_brk), 32'h1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        check("t3_rep_code", 32'(cap_code), 32'h12);
        check("t3_rep_break", 32'(cap_brk), 32'h1);
        check("t3_rep_ext", 32'(cap_ext), 32'h0);

        // 4: parity error drops the frame and a pending break
        mark();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h45, 1'b1);
        check("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(8'h16, 1'b0);
        check("t4_code", 32'(cap_code), 32'h16);
        check("t4_break", 32'(cap_brk), 32'h0);

        // 5: truncated frame times out roughly TIMEOUT cycles after the last edge
        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        keyboardData = 1'b1;
        #2600;
        check("t5_no_early_err", 32'(err_cnt - e0), 32'd0);
        #2400;
        check("t5_timeout_err", 32'(err_cnt - e0), 32'd1);
        check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(8'h3B, 1'b0);
        check("t5_code", 32'(cap_code), 32'h3B);
        check("t5_valid_cnt", 32'(valid_cnt - v0), 32'd1);

        // 6: reset mid-frame after a pending break
        send_frame(8'hF0, 1'b0);
        mark();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        #100 resetN = 1'b0;
        #2;
        check("t6_rst_code", 32'(scanCode), 32'h00);
        check("t6_rst_valid", 32'(scanValid), 32'h0);
        check("t6_rst_err", 32'(frameError), 32'h0);
        #8;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        keyboardData = 1'b1;
        #1000 resetN = 1'b1;
        #1000;
        check("t6_no_strobe", 32'(valid_cnt - v0), 32'd0);
        check("t6_no_err", 32'(err_cnt - e0), 32'd0);
        send_frame(8'h24, 1'b0);
        check("t6_code", 32'(cap_code), 32'h24);
        check("t6_break", 32'(cap_brk), 32'h0);
        check("t6_valid_cnt", 32'(valid_cnt - v0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
